// File: rtl/synt_cal_ctrl_if.sv
// Sequencer <-> synthesizer calibration controller bundle.
// Per-channel request/status vectors plus the shared CAL_LEN.
interface synt_cal_ctrl_if #(
  parameter int NCH   = 4,
  parameter int CNT_W = 16
);
  logic [NCH-1:0]   PU_SYNT;
  logic [NCH-1:0]   CAL_SYNT;
  logic [CNT_W-1:0] CAL_LEN;
  logic [NCH-1:0]   LOCK_LOST;
  logic [NCH-1:0]   RDY_SYNT;
  logic [NCH-1:0]   BUSY_SYNT;
  logic [NCH-1:0]   PEND_SYNT;
  logic             ENG_IDLE;

  modport master (
    output PU_SYNT, CAL_SYNT, CAL_LEN, LOCK_LOST,
    input  RDY_SYNT, BUSY_SYNT, PEND_SYNT, ENG_IDLE
  );

  modport slave (
    input  PU_SYNT, CAL_SYNT, CAL_LEN, LOCK_LOST,
    output RDY_SYNT, BUSY_SYNT, PEND_SYNT, ENG_IDLE
  );
endinterface

// File: rtl/synt_cal_ctrl.sv
// Multi-channel synthesizer power-up/calibration controller, one shared engine.
// Optional: SYNT_AUTO_RECAL_EN re-queues a channel on lock loss.
module synt_cal_ctrl #(
  parameter int NCH        = 4,
  parameter int CNT_W      = 16,
  parameter int CAL_CYCLES = 14000
) (
  input logic            CLK,
  input logic            RST_N,
  synt_cal_ctrl_if.slave bus
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [2:0] {
    S_OFF,
    S_IDLE,
    S_PEND,
    S_CAL,
    S_RDY
  } st_t;

  st_t st_q [NCH];
  st_t st_d [NCH];

  logic             eng_idle_q, eng_idle_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    own_q, own_d;

  logic [NCH-1:0]   pend_v;
  logic             gnt_v;
  logic [PW-1:0]    gnt_idx;
  logic             hi_v, lo_v;
  logic [PW-1:0]    hi_idx, lo_idx;
  logic             cal_done;
  logic [CNT_W-1:0] len;

  // A channel being powered down at this edge is not eligible for grant
  always_comb begin
    pend_v = '0;
    for (int i = 0; i < NCH; i++)
      pend_v[i] = (st_q[i] == S_PEND) && bus.PU_SYNT[i];
  end

  // Round robin: lowest pending index >= ptr, else lowest overall
  always_comb begin
    hi_v   = 1'b0;
    lo_v   = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (pend_v[i]) begin
        lo_v   = 1'b1;
        lo_idx = PW'(i);
        if (i >= int'(ptr_q)) begin
          hi_v   = 1'b1;
          hi_idx = PW'(i);
        end
      end
    end
    gnt_v   = lo_v && eng_idle_q;
    gnt_idx = hi_v ? hi_idx : lo_idx;
  end

  assign cal_done = !eng_idle_q && (cnt_q == '0);
  assign len = (bus.CAL_LEN == '0) ? CNT_W'(CAL_CYCLES)
                                   : bus.CAL_LEN;

  always_comb begin
    eng_idle_d = eng_idle_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    own_d      = own_q;
    if (!eng_idle_q) begin
      if (!bus.PU_SYNT[own_q] || cnt_q == '0) begin
        eng_idle_d = 1'b1;
        cnt_d      = '0;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end else if (gnt_v) begin
      eng_idle_d = 1'b0;
      cnt_d      = len - CNT_W'(1);
      own_d      = gnt_idx;
      ptr_d      = (gnt_idx == PW'(NCH - 1)) ? '0
                                             : gnt_idx + PW'(1);
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      st_d[i] = st_q[i];
      if (!bus.PU_SYNT[i]) begin
        st_d[i] = S_OFF;
      end else begin
        unique case (st_q[i])
          S_OFF:  st_d[i] = S_IDLE;
          S_IDLE: if (bus.CAL_SYNT[i]) st_d[i] = S_PEND;
          S_PEND: if (gnt_v && gnt_idx == PW'(i))
                    st_d[i] = S_CAL;
          S_CAL:  if (cal_done) st_d[i] = S_RDY;
          S_RDY: begin
            if (bus.CAL_SYNT[i]) begin
              st_d[i] = S_PEND;
            end else if (bus.LOCK_LOST[i]) begin
`ifdef SYNT_AUTO_RECAL_EN
              st_d[i] = S_PEND;
`else
              st_d[i] = S_IDLE;
`endif
            end
          end
          default: st_d[i] = S_OFF;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < NCH; i++)
        st_q[i] <= S_OFF;
      eng_idle_q <= 1'b1;
      cnt_q      <= '0;
      ptr_q      <= '0;
      own_q      <= '0;
    end else begin
      for (int i = 0; i < NCH; i++)
        st_q[i] <= st_d[i];
      eng_idle_q <= eng_idle_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      own_q      <= own_d;
    end
  end

  always_comb begin
    bus.RDY_SYNT  = '0;
    bus.BUSY_SYNT = '0;
    bus.PEND_SYNT = '0;
    for (int i = 0; i < NCH; i++) begin
      bus.RDY_SYNT[i]  = (st_q[i] == S_RDY);
      bus.BUSY_SYNT[i] = (st_q[i] == S_CAL);
      bus.PEND_SYNT[i] = (st_q[i] == S_PEND);
    end
    bus.ENG_IDLE = eng_idle_q;
  end

endmodule

// File: tb/tb_synt_cal_ctrl.sv
// Scoreboard bench for synt_cal_ctrl: stimulus queues expected
// per-edge status snapshots, a negedge monitor pops and compares.
module tb_synt_cal_ctrl;

  localparam int NCH   = 4;
  localparam int CNT_W = 16;

  typedef struct {
    int           at;
    string        tag;
    logic [NCH-1:0] rdy;
    logic [NCH-1:0] busy;
    logic [NCH-1:0] pend;
    logic         idle;
  } exp_t;

  logic CLK;
  logic RST_N;
  int   edge_n;
  int   checks;
  int   errors;
  exp_t sb [$];

  synt_cal_ctrl_if #(.NCH(NCH), .CNT_W(CNT_W)) bus ();

  synt_cal_ctrl #(
    .NCH(NCH),
    .CNT_W(CNT_W),
    .CAL_CYCLES(14000)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .bus(bus.slave)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial edge_n = 0;
  always @(posedge CLK) edge_n <= edge_n + 1;

  task automatic push(input int at, input string tag,
                      input logic [NCH-1:0] rdy,
                      input logic [NCH-1:0] busy,
                      input logic [NCH-1:0] pend,
                      input logic idle);
    exp_t e;
    e.at   = at;
    e.tag  = tag;
    e.rdy  = rdy;
    e.busy = busy;
    e.pend = pend;
    e.idle = idle;
    sb.push_back(e);
  endtask

  task automatic go(input int t);
    while (edge_n < t) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Monitor: compare every snapshot due at this edge
  always @(negedge CLK) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].at <= edge_n) begin
      e = sb.pop_front();
      checks++;
      if (e.at < edge_n) begin
        errors++;
        $display("FAIL %s: missed at edge %0d, now %0d",
                 e.tag, e.at, edge_n);
      end else if (bus.RDY_SYNT !== e.rdy ||
                   bus.BUSY_SYNT !== e.busy ||
                   bus.PEND_SYNT !== e.pend ||
                   bus.ENG_IDLE !== e.idle) begin
        errors++;
        $display("FAIL %s @edge %0d: got rdy=%b busy=%b pend=%b idle=%b, need rdy=%b busy=%b pend=%b idle=%b",
                 e.tag, edge_n, bus.RDY_SYNT, bus.BUSY_SYNT,
                 bus.PEND_SYNT, bus.ENG_IDLE, e.rdy, e.busy,
                 e.pend, e.idle);
      end
    end
    if (edge_n > 0) begin
      checks++;
      if ($countones(bus.BUSY_SYNT) > 1 ||
          ((bus.BUSY_SYNT != '0) == bus.ENG_IDLE)) begin
        errors++;
        $display("FAIL invariant @edge %0d: busy=%b idle=%b",
                 edge_n, bus.BUSY_SYNT, bus.ENG_IDLE);
      end
    end
  end

  int k, b, c, d, f, g, h;
  logic [NCH-1:0] r1;

  initial begin
    checks = 0;
    errors = 0;
    RST_N = 1'b0;
    bus.PU_SYNT   = '0;
    bus.CAL_SYNT  = '0;
    bus.LOCK_LOST = '0;
    bus.CAL_LEN   = 16'd10;

    go(2);
    push(2, "reset", 4'b0000, 4'b0000, 4'b0000, 1'b1);
    RST_N = 1'b1;
    bus.PU_SYNT = 4'b0001;

    // single request, L=10
    go(3);
    bus.CAL_SYNT = 4'b0001;
    go(4);
    bus.CAL_SYNT = '0;
    k = edge_n;
    push(k,      "t1_pend",  4'b0000, 4'b0000, 4'b0001, 1'b1);
    push(k + 1,  "t1_grant", 4'b0000, 4'b0001, 4'b0000, 1'b0);
    push(k + 10, "t1_last",  4'b0000, 4'b0001, 4'b0000, 1'b0);
    push(k + 11, "t1_rdy",   4'b0001, 4'b0000, 4'b0000, 1'b1);
    push(k + 12, "t1_hold",  4'b0001, 4'b0000, 4'b0000, 1'b1);
    go(k + 12);

    // recalibration with CAL_LEN=0 -> 14000 cycles
    b = edge_n;
    bus.CAL_LEN  = '0;
    bus.CAL_SYNT = 4'b0001;
    push(b + 1,     "t2_pend",  4'b0000, 4'b0000, 4'b0001, 1'b1);
    push(b + 2,     "t2_grant", 4'b0000, 4'b0001, 4'b0000, 1'b0);
    push(b + 14001, "t2_last",  4'b0000, 4'b0001, 4'b0000, 1'b0);
    push(b + 14002, "t2_rdy",   4'b0001, 4'b0000, 4'b0000, 1'b1);
    go(b + 1);
    bus.CAL_SYNT = '0;
    go(b + 14003);

    // channels 1 and 3 request together, L=4
    c = edge_n;
    bus.PU_SYNT = 4'b1011;
    bus.CAL_LEN = 16'd4;
    go(c + 1);
    bus.CAL_SYNT = 4'b1010;
    go(c + 2);
    bus.CAL_SYNT = '0;
    push(c + 2,  "t3_pend",   4'b0001, 4'b0000, 4'b1010, 1'b1);
    push(c + 3,  "t3_g1",     4'b0001, 4'b0010, 4'b1000, 1'b0);
    push(c + 6,  "t3_g1_end", 4'b0001, 4'b0010, 4'b1000, 1'b0);
    push(c + 7,  "t3_rdy1",   4'b0011, 4'b0000, 4'b1000, 1'b1);
    push(c + 8,  "t3_g3",     4'b0011, 4'b1000, 4'b0000, 1'b0);
    push(c + 11, "t3_g3_end", 4'b0011, 4'b1000, 4'b0000, 1'b0);
    push(c + 12, "t3_rdy3",   4'b1011, 4'b0000, 4'b0000, 1'b1);
    go(c + 12);

    // ch2 calibrating, powered down at counter==5, ch0 waiting
    d = edge_n;
    bus.PU_SYNT = 4'b1111;
    bus.CAL_LEN = 16'd10;
    go(d + 1);
    bus.CAL_SYNT = 4'b0100;
    go(d + 2);
    bus.CAL_SYNT = '0;
    push(d + 2,  "t4_pend2",  4'b1011, 4'b0000, 4'b0100, 1'b1);
    push(d + 3,  "t4_g2",     4'b1011, 4'b0100, 4'b0000, 1'b0);
    push(d + 4,  "t4_pend0",  4'b1010, 4'b0100, 4'b0001, 1'b0);
    push(d + 7,  "t4_cnt5",   4'b1010, 4'b0100, 4'b0001, 1'b0);
    push(d + 8,  "t4_abort",  4'b1010, 4'b0000, 4'b0001, 1'b1);
    push(d + 9,  "t4_g0",     4'b1010, 4'b0001, 4'b0000, 1'b0);
    push(d + 19, "t4_rdy0",   4'b1011, 4'b0000, 4'b0000, 1'b1);
    go(d + 3);
    bus.CAL_SYNT = 4'b0001;
    go(d + 4);
    bus.CAL_SYNT = '0;
    go(d + 7);
    bus.PU_SYNT = 4'b1011;
    go(d + 8);
    bus.PU_SYNT = 4'b1111;
    go(d + 19);

    // pointer now 1: ch0 and ch3 together -> ch3 first
    f = edge_n;
    bus.CAL_SYNT = 4'b1001;
    push(f + 1,  "t5_pend",  4'b0010, 4'b0000, 4'b1001, 1'b1);
    push(f + 2,  "t5_g3",    4'b0010, 4'b1000, 4'b0001, 1'b0);
    push(f + 12, "t5_rdy3",  4'b1010, 4'b0000, 4'b0001, 1'b1);
    push(f + 13, "t5_g0",    4'b1010, 4'b0001, 4'b0000, 1'b0);
    push(f + 23, "t5_rdy0",  4'b1011, 4'b0000, 4'b0000, 1'b1);
    go(f + 1);
    bus.CAL_SYNT = '0;
    go(f + 23);

    // lock loss on ch0 (RDY) and ch2 (IDLE, ignored)
    g = edge_n;
    bus.LOCK_LOST = 4'b0101;
`ifdef SYNT_AUTO_RECAL_EN
    push(g + 1,  "t6_lock",  4'b1010, 4'b0000, 4'b0001, 1'b1);
    push(g + 2,  "t6_regnt", 4'b1010, 4'b0001, 4'b0000, 1'b0);
    push(g + 12, "t6_rerdy", 4'b1011, 4'b0000, 4'b0000, 1'b1);
    r1 = 4'b1001;
    go(g + 1);
    bus.LOCK_LOST = '0;
    go(g + 13);
`else
    push(g + 1,  "t6_lock",  4'b1010, 4'b0000, 4'b0000, 1'b1);
    push(g + 3,  "t6_stay",  4'b1010, 4'b0000, 4'b0000, 1'b1);
    r1 = 4'b1000;
    go(g + 1);
    bus.LOCK_LOST = '0;
    go(g + 3);
`endif

    // reset during ch1 calibration, CAL_SYNT[1] held high
    h = edge_n;
    bus.CAL_SYNT = 4'b0010;
    push(h + 1,  "t7_pend",   r1, 4'b0000, 4'b0010, 1'b1);
    push(h + 2,  "t7_g1",     r1, 4'b0010, 4'b0000, 1'b0);
    push(h + 4,  "t7_cal",    r1, 4'b0010, 4'b0000, 1'b0);
    push(h + 5,  "t7_reset",  4'b0000, 4'b0000, 4'b0000, 1'b1);
    push(h + 6,  "t7_idle",   4'b0000, 4'b0000, 4'b0000, 1'b1);
    push(h + 7,  "t7_repend", 4'b0000, 4'b0000, 4'b0010, 1'b1);
    push(h + 8,  "t7_regnt",  4'b0000, 4'b0010, 4'b0000, 1'b0);
    push(h + 17, "t7_last",   4'b0000, 4'b0010, 4'b0000, 1'b0);
    push(h + 18, "t7_rdy",    4'b0010, 4'b0000, 4'b0000, 1'b1);
    go(h + 4);
    RST_N = 1'b0;
    go(h + 5);
    RST_N = 1'b1;
    go(h + 8);
    bus.CAL_SYNT = '0;
    go(h + 20);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d snapshots left, need 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/synt_cal_ctrl.md
Name: synt_cal_ctrl

Overview:
- Parametrised multi-channel successor to the single synthesizer power-up/calibration model.
- Tracks NCH synthesizer channels, each with its own power-up and calibration request.
- Calibrations are serialised through one shared calibration engine, with round-robin arbitration and a cycle-counted calibration time in place of a simulation delay.
- Drives per-channel ready/busy status to the radio sequencer.

Parameters:
- NCH, 4, number of synthesizer channels (1..16)
- CNT_W, 16, width of the calibration cycle counter and CAL_LEN
- CAL_CYCLES, 14000, default calibration length in CLK cycles when CAL_LEN==0 (must fit CNT_W)

Ports:
- CLK  in  1  clock, all logic on rising edge
- RST_N  in  1  synchronous active-low reset
- PU_SYNT  in  NCH  per-channel power-up level
- CAL_SYNT  in  NCH  per-channel calibration request (level, sampled each edge)
- CAL_LEN  in  CNT_W  calibration length in cycles, sampled at grant; 0 selects CAL_CYCLES
- LOCK_LOST  in  NCH  per-channel lock-loss pulse from the synthesizer
- RDY_SYNT  out  NCH  channel calibrated and powered
- BUSY_SYNT  out  NCH  channel currently owns the calibration engine (one-hot or zero)
- PEND_SYNT  out  NCH  request latched, waiting for engine
- ENG_IDLE  out  1  shared engine free

Behaviour:
- Reset (RST_N low at an edge): RDY_SYNT=0, BUSY_SYNT=0, PEND_SYNT=0, ENG_IDLE=1, counter=0, round-robin pointer=0. Reset mid-calibration aborts immediately.
- Per-channel states: OFF, IDLE, PEND, CAL, RDY. Outputs are decoded from registered state.
- Any state with PU_SYNT[i]=0 at an edge goes to OFF.
  - This is synchronous and overrides everything else for that channel, including an in-progress CAL.
  - An aborted CAL frees the engine at that same edge (ENG_IDLE=1 after the edge).
- OFF -> IDLE when PU_SYNT[i]=1.
- IDLE -> PEND when CAL_SYNT[i]=1 and PU_SYNT[i]=1.
- RDY -> PEND on CAL_SYNT[i]=1 (recalibration). RDY_SYNT[i] drops at that edge.
- CAL_SYNT ignored while in PEND or CAL. CAL_SYNT with PU_SYNT=0 is ignored.
- Arbitration: at an edge where ENG_IDLE=1 and at least one channel is in PEND, grant exactly one.
  - Search order starts at pointer, ascending with wrap (NCH-1 -> 0).
  - Granted channel goes PEND -> CAL.
  - Pointer <= granted index+1, mod NCH.
  - Counter <= L-1, where L = CAL_LEN, or CAL_CYCLES if CAL_LEN==0.
  - ENG_IDLE <= 0.
- A request latched at edge k is granted no earlier than edge k+1 (PEND visible for at least one cycle).
- CAL: counter decrements each edge. At the edge where counter==0: channel CAL -> RDY, ENG_IDLE <= 1.
  - BUSY_SYNT[i] is high for exactly L cycles.
  - RDY_SYNT[i] rises at grant edge + L.
- Next grant earliest at the edge after the engine frees, so there is one idle cycle between back-to-back calibrations.
- LOCK_LOST[i] in RDY (build without the optional feature): RDY -> IDLE, RDY_SYNT[i] drops next edge. LOCK_LOST is ignored in other states.
- Simultaneous events on one channel, priority: PU_SYNT low > CAL_SYNT > LOCK_LOST.
- Width rule: CAL_LEN is used unsigned. L=1 gives BUSY for one cycle.
- Invariant: popcount(BUSY_SYNT) <= 1; BUSY_SYNT != 0 iff ENG_IDLE == 0.

Optional Feature:
- Macro: SYNT_AUTO_RECAL_EN.
- Defined: LOCK_LOST[i] in RDY moves the channel RDY -> PEND, so it re-enters arbitration automatically with no new CAL_SYNT. RDY_SYNT[i] drops at that edge.
- Not defined: LOCK_LOST[i] moves RDY -> IDLE. The sequencer must reissue CAL_SYNT.

Test Plan:
- NCH=4, CAL_LEN=10, PU_SYNT[0]=1, CAL_SYNT[0] pulse at edge 5 -> PEND_SYNT[0] after edge 5; BUSY_SYNT[0] cycles 6..15; RDY_SYNT[0]=1 from edge 16; ENG_IDLE returns 1 at edge 16.
- CAL_LEN=0, single request -> BUSY high exactly 14000 cycles, then RDY.
- PU on channels 1 and 3, simultaneous CAL_SYNT, CAL_LEN=4, pointer=0 -> channel 1 granted first (RDY1 at grant+4); channel 3 granted one edge after the engine frees; pointer ends at 0.
- Channel 2 in CAL, PU_SYNT[2] dropped at counter==5 -> BUSY_SYNT[2] and PEND/RDY cleared next edge; ENG_IDLE=1; a pending channel 0 granted on the following edge.
- Channel 0 RDY, LOCK_LOST[0] pulse -> RDY_SYNT[0]=0 and state IDLE. With SYNT_AUTO_RECAL_EN: PEND, then recalibrated to RDY after L cycles.
- Channel 1 in CAL with RST_N low for one edge -> all outputs at reset values next cycle; CAL_SYNT held high after reset -> fresh grant with full L count.
